// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU datapath.
package cpu16_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of write-back entries; exposes every slot and its
// valid bit so the owner can reduce over queued destinations.
module wb_fifo
    import cpu16_pkg::*;
#(
    parameter type         entry_t = wb_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       entry_valid,
    output entry_t [DEPTH-1:0]     entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   offs;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        offs        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs           = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = {1'b0, offs} < count_q;
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign entries = mem_q;
    assign count   = count_q;
    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back queue owning the register file's single write port: arbitrates ALU
// and load results into a FIFO, issues one write per cycle, publishes pending mask.
module regfile_writeback #(
    parameter int unsigned DATA_W = cpu16_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu16_pkg::REG_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   wr_grant,
    output logic                   reg_write_en,
    output logic [ADDR_W-1:0]      reg_write_dest,
    output logic [DATA_W-1:0]      reg_write_data,
    output logic [2**ADDR_W-1:0]   pend_mask,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic               full, empty;
    logic               mem_push, alu_push, push, pop;
    entry_t             push_entry, head;
    logic [DEPTH-1:0]   entry_valid;
    entry_t [DEPTH-1:0] entries;

    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_dest_q;
    logic [DATA_W-1:0]  wr_data_q;

    // Ready ignores a same-cycle pop so a full FIFO never takes a push.
    always_comb begin
        mem_ready = rst_n && !full;
        alu_ready = rst_n && !full && !mem_valid;
        mem_push  = mem_valid && mem_ready;
        alu_push  = alu_valid && alu_ready;
        push      = mem_push || alu_push;
        if (mem_push) begin
            push_entry = '{dest: mem_dest, data: mem_data};
        end else begin
            push_entry = '{dest: alu_dest, data: alu_data};
        end
        pop = !empty && wr_grant;
    end

    wb_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= pop;
            if (pop) begin
                wr_dest_q <= head.dest;
                wr_data_q <= head.data;
            end
        end
    end

    // The issuing register stays marked until the register file captures it.
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask[entries[i].dest] = 1'b1;
            end
        end
        if (wr_en_q) begin
            pend_mask[wr_dest_q] = 1'b1;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic scored
// against a queue model of acceptance order and write issue.
module tb_regfile_writeback;
    import cpu16_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned NR    = NUM_REGS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0, wr_grant = 1'b0;
    logic [AW-1:0] alu_dest = '0, mem_dest = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, reg_write_en;
    logic [AW-1:0] reg_write_dest;
    logic [DW-1:0] reg_write_data;
    logic [NR-1:0] pend_mask;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    regfile_writeback #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_dest       (mem_dest),
        .mem_data       (mem_data),
        .wr_grant       (wr_grant),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pend_mask      (pend_mask),
        .count          (count)
    );

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } ref_t;

    ref_t          q[$];
    logic          m_en = 1'b0;
    logic [AW-1:0] m_dest = '0;
    logic [DW-1:0] m_data = '0;
    int            src_cnt[2] = '{0, 0};
    int            n_checks = 0;
    int            n_pass = 0;

    function automatic logic [NR-1:0] m_pend();
        logic [NR-1:0] m = '0;
        foreach (q[i]) m[q[i].dest] = 1'b1;
        if (m_en) m[m_dest] = 1'b1;
        return m;
    endfunction

    // One clock edge; the model applies the same edge using the inputs it saw.
    task automatic tick();
        ref_t h;
        bit   was_full;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_en = 1'b0; m_dest = '0; m_data = '0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (q.size() > 0 && wr_grant) begin
                h = q.pop_front();
                m_en = 1'b1; m_dest = h.dest; m_data = h.data;
            end else begin
                m_en = 1'b0;
            end
            if (!was_full) begin
                if (mem_valid) begin
                    h.dest = mem_dest; h.data = mem_data; q.push_back(h);
                    src_cnt[int'(SRC_MEM)]++;
                end else if (alu_valid) begin
                    h.dest = alu_dest; h.data = alu_data; q.push_back(h);
                    src_cnt[int'(SRC_ALU)]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234; wr_grant = 1'b1;
        #1;
        n_checks++; if (alu_ready !== 1'b0) $display("FAIL rst_alu_ready: got %b want 0", alu_ready); else n_pass++;
        n_checks++; if (mem_ready !== 1'b0) $display("FAIL rst_mem_ready: got %b want 0", mem_ready); else n_pass++;
        tick(); tick();
        n_checks++; if (count !== '0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (reg_write_en !== 1'b0) $display("FAIL rst_en: got %b want 0", reg_write_en); else n_pass++;
        n_checks++; if (reg_write_dest !== '0 || reg_write_data !== '0)
            $display("FAIL rst_out: got %0d/%h want 0/0000", reg_write_dest, reg_write_data); else n_pass++;
        n_checks++; if (pend_mask !== '0) $display("FAIL rst_pend: got %h want 00", pend_mask); else n_pass++;
        rst_n = 1'b1; alu_valid = 1'b0;
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1)
            $display("FAIL post_rst_ready: got alu %b mem %b want 1 1", alu_ready, mem_ready); else n_pass++;
    endtask

    task automatic test_single();
        wr_grant = 1'b1; alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'hBEEF;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (pend_mask !== 8'h08 || reg_write_en !== 1'b0)
            $display("FAIL single_c1: got pend %h en %b want 08 0", pend_mask, reg_write_en); else n_pass++;
        tick();
        n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hBEEF)
            $display("FAIL single_c2: got %b %0d %h want 1 3 beef", reg_write_en, reg_write_dest, reg_write_data);
        else n_pass++;
        n_checks++; if (pend_mask !== 8'h08) $display("FAIL single_pend_c2: got %h want 08", pend_mask); else n_pass++;
        tick();
        n_checks++; if (reg_write_en !== 1'b0 || pend_mask !== 8'h00 || reg_write_data !== 16'hBEEF)
            $display("FAIL single_c3: got en %b pend %h data %h want 0 00 beef", reg_write_en, pend_mask,
                     reg_write_data); else n_pass++;
    endtask

    task automatic test_priority();
        wr_grant = 1'b1;
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h0011;
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h0022;
        #1;
        n_checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL prio_ready: got alu %b mem %b want 0 1", alu_ready, mem_ready); else n_pass++;
        tick();
        mem_valid = 1'b0;
        #1;
        n_checks++; if (alu_ready !== 1'b1) $display("FAIL prio_alu_ready: got %b want 1", alu_ready); else n_pass++;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd2 || reg_write_data !== 16'h0022)
            $display("FAIL prio_first: got %b %0d %h want 1 2 0022", reg_write_en, reg_write_dest, reg_write_data);
        else n_pass++;
        tick();
        n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd1 || reg_write_data !== 16'h0011)
            $display("FAIL prio_second: got %b %0d %h want 1 1 0011", reg_write_en, reg_write_dest, reg_write_data);
        else n_pass++;
        tick();
        n_checks++; if (reg_write_en !== 1'b0 || pend_mask !== '0)
            $display("FAIL prio_idle: got en %b pend %h want 0 00", reg_write_en, pend_mask); else n_pass++;
    endtask

    task automatic test_backpressure();
        wr_grant = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            alu_valid = 1'b1; alu_dest = AW'(i); alu_data = DW'(i);
            #1;
            if (i < 5) begin
                n_checks++; if (alu_ready !== 1'b1)
                    $display("FAIL bp_ready_%0d: got %b want 1", i, alu_ready); else n_pass++;
                tick();
            end else begin
                n_checks++; if (alu_ready !== 1'b0 || count !== CW'(4))
                    $display("FAIL bp_full: got ready %b count %0d want 0 4", alu_ready, count); else n_pass++;
            end
        end
        wr_grant = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) alu_valid = 1'b0;
            n_checks++; if (reg_write_en !== 1'b1 || reg_write_data !== DW'(k))
                $display("FAIL bp_issue_%0d: got %b %h want 1 %h", k, reg_write_en, reg_write_data, DW'(k));
            else n_pass++;
        end
        tick();
        n_checks++; if (reg_write_en !== 1'b0 || count !== '0)
            $display("FAIL bp_drain: got en %b count %0d want 0 0", reg_write_en, count); else n_pass++;
    endtask

    task automatic test_same_dest();
        wr_grant = 1'b0; alu_valid = 1'b1; alu_dest = 3'd7; alu_data = 16'hAAAA;
        tick();
        alu_data = 16'h5555;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (pend_mask !== 8'h80 || count !== CW'(2))
            $display("FAIL same_queued: got pend %h count %0d want 80 2", pend_mask, count); else n_pass++;
        wr_grant = 1'b1;
        tick();
        n_checks++; if (reg_write_data !== 16'hAAAA || pend_mask[7] !== 1'b1)
            $display("FAIL same_first: got %h pend7 %b want aaaa 1", reg_write_data, pend_mask[7]); else n_pass++;
        tick();
        n_checks++; if (reg_write_en !== 1'b1 || reg_write_data !== 16'h5555 || pend_mask[7] !== 1'b1)
            $display("FAIL same_second: got %b %h pend7 %b want 1 5555 1", reg_write_en, reg_write_data,
                     pend_mask[7]); else n_pass++;
        tick();
        n_checks++; if (pend_mask[7] !== 1'b0) $display("FAIL same_clear: got %b want 0", pend_mask[7]); else n_pass++;
    endtask

    task automatic test_grant_gap();
        bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int idx = 0;
        wr_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dest = AW'(4 + i); alu_data = DW'(16'h0040 + i);
            tick();
        end
        alu_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wr_grant = pat[j];
            tick();
            n_checks++; if (reg_write_en !== pat[j])
                $display("FAIL gap_en_%0d: got %b want %b", j, reg_write_en, pat[j]); else n_pass++;
            if (pat[j]) begin
                n_checks++; if (reg_write_data !== DW'(16'h0040 + idx))
                    $display("FAIL gap_data_%0d: got %h want %h", j, reg_write_data, DW'(16'h0040 + idx));
                else n_pass++;
                idx++;
            end
        end
        n_checks++; if (count !== '0) $display("FAIL gap_count: got %0d want 0", count); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        wr_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_dest = AW'(i); alu_data = DW'(16'h0100 + i);
            tick();
        end
        alu_valid = 1'b0; wr_grant = 1'b1;
        tick();
        n_checks++; if (reg_write_en !== 1'b1 || count !== CW'(3))
            $display("FAIL mid_pre: got en %b count %0d want 1 3", reg_write_en, count); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (count !== '0 || reg_write_en !== 1'b0 || pend_mask !== '0)
            $display("FAIL mid_rst: got count %0d en %b pend %h want 0 0 00", count, reg_write_en, pend_mask);
        else n_pass++;
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h55AA;
        tick();
        alu_valid = 1'b0;
        tick();
        n_checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd5 || reg_write_data !== 16'h55AA)
            $display("FAIL mid_fresh: got %b %0d %h want 1 5 55aa", reg_write_en, reg_write_dest, reg_write_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic exp_mr, exp_ar;
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            alu_valid = 1'($urandom_range(0, 1));
            mem_valid = ($urandom_range(0, 3) == 0);
            wr_grant  = ($urandom_range(0, 3) != 0);
            alu_dest  = AW'($urandom); alu_data = DW'($urandom);
            mem_dest  = AW'($urandom); mem_data = DW'($urandom);
            #1;
            exp_mr = rst_n && (q.size() < DEPTH);
            exp_ar = exp_mr && !mem_valid;
            n_checks++; if (mem_ready !== exp_mr)
                $display("FAIL rnd_mem_ready c%0d: got %b want %b", c, mem_ready, exp_mr); else n_pass++;
            n_checks++; if (alu_ready !== exp_ar)
                $display("FAIL rnd_alu_ready c%0d: got %b want %b", c, alu_ready, exp_ar); else n_pass++;
            tick();
            n_checks++; if (count !== CW'(q.size()))
                $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, q.size()); else n_pass++;
            n_checks++; if (reg_write_en !== m_en)
                $display("FAIL rnd_en c%0d: got %b want %b", c, reg_write_en, m_en); else n_pass++;
            n_checks++; if (reg_write_dest !== m_dest || reg_write_data !== m_data)
                $display("FAIL rnd_out c%0d: got %0d/%h want %0d/%h", c, reg_write_dest, reg_write_data,
                         m_dest, m_data); else n_pass++;
            n_checks++; if (pend_mask !== m_pend())
                $display("FAIL rnd_pend c%0d: got %h want %h", c, pend_mask, m_pend()); else n_pass++;
        end
        rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_same_dest();
        test_grant_gap();
        test_reset_mid();
        test_random();
        $display("source coverage: alu=%0d mem=%0d", src_cnt[int'(SRC_ALU)], src_cnt[int'(SRC_MEM)]);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back queue for the 16-bit CPU that owns the register file's single write port. It accepts results from the ALU and the load unit over valid/ready handshakes, buffers them in order in a small FIFO, and issues at most one write per cycle to the register file. It also publishes a per-register pending mask so decode can stall on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when valid
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle when valid
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- wr_grant  in  1  write port available; low blocks issue
- reg_write_en  out  1  register-file write strobe
- reg_write_dest  out  ADDR_W  register-file write address
- reg_write_data  out  DATA_W  register-file write data
- pend_mask  out  2**ADDR_W  bit r set while any queued or issuing write targets r
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: at most one per cycle. mem has priority over alu.
  - mem_ready = rst_n && !full.
  - alu_ready = rst_n && !full && !mem_valid.
  - A source is accepted when its valid and ready are both high at the edge.
- Full means count == DEPTH. A push into a full FIFO is impossible by construction, including when a pop happens in the same cycle. Ready is conservative.
- Pop/issue, evaluated at each edge:
  - If count > 0 and wr_grant is high: load the head into the output stage, set reg_write_en = 1, and advance the read pointer.
  - Otherwise: reg_write_en = 0; reg_write_dest and reg_write_data hold their previous values.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count saturates at neither end; it is bounded by the ready logic.
- Writes to the same register leave in acceptance order, so the last accepted value wins. No merging or cancellation.
- pend_mask is combinational. It is the OR over the valid FIFO entries' dest one-hots and the output stage's dest when reg_write_en = 1. A register whose write is issuing this cycle stays marked until the register file has captured it.
- Register 0 has no special meaning; it is written like any other register.
- Reset (rst_n low at an edge):
  - count, pointers = 0.
  - reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0.
  - Queued entries are discarded, so pend_mask = 0 after that edge.
  - A handshake in the same cycle as reset is dropped.

## Timing
- Accept at edge k → reg_write_en high in cycle k+1, provided the FIFO was empty and wr_grant was high at edge k+1 → register file captures at edge k+2.
- Sustained throughput: 1 write/cycle while wr_grant stays high.
- wr_grant low for n cycles delays every queued entry by n cycles. The ALU stalls once DEPTH entries are pending.
- Outputs after reset:
  - alu_ready = mem_ready = 1 (when mem_valid is low), count = 0, pend_mask = 0, reg_write_en = 0.
  - While rst_n is low, both readies read 0.

## Structure
- Shared package cpu16_pkg holds:
  - DATA_W, REG_ADDR_W, NUM_REGS constants.
  - wb_entry_t typedef (dest, data).
  - The wb_src_e enum (SRC_ALU, SRC_MEM), used for coverage.
- Sub-module wb_fifo: a parameterised synchronous FIFO of wb_entry_t with push, pop, head, count and full/empty. It also exposes its entry valid vector plus dest array for the pend_mask reduction.
- The top level contains arbitration, the output stage and the pend_mask logic.

## Test plan
- Single write: alu_valid with dest 3 and 16'hBEEF at edge 1, wr_grant = 1 → reg_write_en = 1 with dest 3, data BEEF in cycle 2 only. pend_mask = 8'h08 in cycles 1–2, then 8'h00.
- Priority: alu and mem both valid (alu dest 1 = 16'h0011, mem dest 2 = 16'h0022) → alu_ready = 0. Writes issue in order dest 2 then dest 1 on consecutive cycles.
- Backpressure: wr_grant = 0, push 5 ALU results 16'h0001..16'h0005 → count reaches 4 and alu_ready = 0 on the 5th. After raising wr_grant, the writes issue 1..5 in order, one per cycle.
- Same-destination ordering: push dest 7 = 16'hAAAA then dest 7 = 16'h5555 → two writes in that order. pend_mask bit 7 clears only after the second issues.
- Grant gap: 3 entries queued, wr_grant pattern 1,0,1,1 → reg_write_en pattern 1,0,1,1 with no entry lost or duplicated.
- Reset mid-operation: 3 entries queued and one issuing, rst_n low for one edge → next cycle count = 0, reg_write_en = 0, pend_mask = 0. A fresh push afterwards issues normally.
